// File: rtl/timing_decoder.sv
// Registered N-to-2^N one-hot decoder: direct select decode or free-running timing-state sequence.
// One-cycle latency from any input to out/step/out_valid/wrap; no backpressure, the block advances every enabled edge.
module timing_decoder #(
  parameter  int SEL_W = 3,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             mode,
  input  logic             sel_valid,
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  input  logic [SEL_W-1:0] last_step,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] step,
  output logic             out_valid,
  output logic             wrap
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   step_q, step_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               wrap_q, wrap_d;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    wrap_d  = 1'b0;
    if (clr) begin
      state_d = IDLE;
      step_d  = '0;
    end else if (!mode) begin
      if (sel_valid) begin
        state_d = ACTIVE;
        step_d  = sel;
      end
    end else if (en) begin
      if (state_q == IDLE) begin
        state_d = ACTIVE;
        step_d  = '0;
      end else if (step_q >= last_step) begin
        // Compare before increment so a full-range sequence never overflows.
        step_d = '0;
        wrap_d = 1'b1;
      end else begin
        step_d = step_q + SEL_W'(1);
      end
    end
    out_d = '0;
    if (state_d == ACTIVE) begin
      out_d[step_d] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      out_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      out_q   <= out_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out       = out_q;
  assign step      = step_q;
  assign out_valid = (state_q == ACTIVE);
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_timing_decoder.sv
// Scoreboard bench for timing_decoder: driver pushes model expectations, monitor pops and compares each cycle.
module tb_timing_decoder;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             mode;
  logic             sel_valid;
  logic [SEL_W-1:0] sel;
  logic             en;
  logic [SEL_W-1:0] last_step;
  logic [OUT_W-1:0] out;
  logic [SEL_W-1:0] step;
  logic             out_valid;
  logic             wrap;

  timing_decoder #(.SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .mode      (mode),
    .sel_valid (sel_valid),
    .sel       (sel),
    .en        (en),
    .last_step (last_step),
    .out       (out),
    .step      (step),
    .out_valid (out_valid),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int out;
    int step;
    int vld;
    int wrp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: sequence position as a plain integer, active flag, last wrap.
  int m_active = 0;
  int m_step   = 0;
  int m_wrap   = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic cyc(input logic c, input logic md, input logic sv, input int sl,
                     input logic e, input int ls);
    exp_t x;
    @(negedge clk);
    clr = c; mode = md; sel_valid = sv; en = e;
    sel = SEL_W'(sl); last_step = SEL_W'(ls);
    m_wrap = 0;
    if (c) begin
      m_active = 0;
      m_step   = 0;
    end else if (!md) begin
      if (sv) begin
        m_active = 1;
        m_step   = sl;
      end
    end else if (e) begin
      if (m_active == 0) begin
        m_active = 1;
        m_step   = 0;
      end else if (m_step >= ls) begin
        m_step = 0;
        m_wrap = 1;
      end else begin
        m_step = m_step + 1;
      end
    end
    x.out  = m_active ? (1 << m_step) : 0;
    x.step = m_step;
    x.vld  = m_active;
    x.wrp  = m_wrap;
    exp_q.push_back(x);
  endtask

  task automatic async_rst();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out",  int'(out), 0);
    chk("arst_step", int'(step), 0);
    chk("arst_vld",  int'(out_valid), 0);
    chk("arst_wrap", int'(wrap), 0);
    m_active = 0; m_step = 0; m_wrap = 0;
    clr = 1'b0; mode = 1'b0; sel_valid = 1'b0; en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out",       int'(out), e.out);
        chk("step",      int'(step), e.step);
        chk("out_valid", int'(out_valid), e.vld);
        chk("wrap",      int'(wrap), e.wrp);
      end
    end
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; mode = 1'b0; sel_valid = 1'b0;
    sel = '0; en = 1'b0; last_step = '0;
    #2;
    chk("rst_out",  int'(out), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_vld",  int'(out_valid), 0);
    chk("rst_wrap", int'(wrap), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Direct decode then latch with sel_valid low.
    cyc(0, 0, 1, 5, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, $urandom_range(7), 1, $urandom_range(7));
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, i, 0, 0);

    // Sequence with wrap at 3 from idle.
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 1, 3);

    // Gated enable, then last_step = 0.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 7);
    cyc(0, 1, 0, 0, 0, 7);
    cyc(0, 1, 0, 0, 1, 7);
    cyc(0, 1, 0, 0, 1, 7);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 1, 0);

    // Direct step beyond last_step, then sequence wraps.
    cyc(0, 0, 1, 6, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 7, 1, 2);

    // Mode 1 -> 0 freezes until sel_valid.
    cyc(0, 0, 0, 3, 1, 7);
    cyc(0, 0, 0, 3, 1, 7);

    // Full-range sequence, clr beats en at step 4.
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1, 7);
    cyc(1, 1, 0, 0, 1, 7);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 1, 7);

    // Asynchronous reset mid-sequence, restart from T0.
    async_rst();
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 1, 7);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(199) == 0) async_rst();
      cyc(($urandom_range(15) == 0), $urandom_range(1), $urandom_range(1),
          $urandom_range(7), ($urandom_range(3) != 0), $urandom_range(7));
    end

    @(negedge clk);
    @(posedge clk);
    #2;
    chk("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
